// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Each accepted byte gets a one-cycle start pulse; a watchdog aborts a transmitter that never finishes.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned TIMEOUT    = 200000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [NUM_REQ-1:0]          byte_sent,
  output logic                        timeout_err,
  input  logic                        clear_err
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned ToW  = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned GapW = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StGap} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [IdW-1:0]      grant_q, grant_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]  byte_sent_q, byte_sent_d;
  logic                err_q, err_d;
  logic [ToW-1:0]      to_cnt_q, to_cnt_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;

  logic                found;
  logic [IdW-1:0]      winner;
  logic [IdW-1:0]      idx;
  logic [DATA_W-1:0]   sel_data;
  logic                err_set;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IdW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdW'(i) == winner) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    byte_sent_d = '0;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    err_set     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          tx_data_d  = sel_data;
          grant_d    = winner;
          ptr_d      = winner;
          tx_start_d = 1'b1;
          state_d    = StLaunch;
        end
      end
      StLaunch: begin
        to_cnt_d = '0;
        state_d  = StBusy;
      end
      StBusy: begin
        // A done on the final watchdog cycle still counts as a completed byte.
        if (tx_done) begin
          byte_sent_d[grant_q] = 1'b1;
          gap_cnt_d            = '0;
          state_d              = (GAP_CYCLES > 0) ? StGap : StIdle;
        end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_set) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= IdW'(NUM_REQ - 1);
      grant_q     <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      byte_sent_q <= '0;
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      byte_sent_q <= byte_sent_d;
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign byte_sent   = byte_sent_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Drives two arbiters (with and without an inter-byte gap) from shared requesters and checks
// every output each cycle against a timestamp-based model of the transfer schedule.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int TO   = 100;
  localparam int GAP0 = 5;
  localparam int NCYC = 2900;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic             clear_err;
  logic             tx_done     [2];
  logic [NR-1:0]    req_ready   [2];
  logic             tx_start    [2];
  logic [DW-1:0]    tx_data     [2];
  logic             busy        [2];
  logic [1:0]       grant_id    [2];
  logic [NR-1:0]    byte_sent   [2];
  logic             timeout_err [2];

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GAP0), .TIMEOUT(TO)
  ) u_dut_gap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .tx_done(tx_done[0]), .busy(busy[0]), .grant_id(grant_id[0]),
    .byte_sent(byte_sent[0]), .timeout_err(timeout_err[0]), .clear_err(clear_err)
  );

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(0), .TIMEOUT(TO)
  ) u_dut_nogap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .tx_done(tx_done[1]), .busy(busy[1]), .grant_id(grant_id[1]),
    .byte_sent(byte_sent[1]), .timeout_err(timeout_err[1]), .clear_err(clear_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: each transfer is a set of timestamps rather than a state.
  bit          in_xfer    [2];
  int          idle_from  [2];
  int          launch_cyc [2];
  int          done_cyc   [2];  // -1: UART never answers
  int          sent_cyc   [2];
  int          sent_id    [2];
  int          ptr        [2];
  int          m_grant    [2];
  logic [7:0]  m_data     [2];
  bit          m_err      [2];
  int          force_delay;      // -2: random UART latency
  bit          rst_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int gap_of(input int u);
    return (u == 0) ? GAP0 : 0;
  endfunction

  function automatic int rr_pick(input int p, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset(input int n);
    for (int u = 0; u < 2; u++) begin
      in_xfer[u]    = 1'b0;
      idle_from[u]  = n + 1;
      launch_cyc[u] = -10;
      done_cyc[u]   = -1;
      sent_cyc[u]   = -10;
      sent_id[u]    = 0;
      ptr[u]        = NR - 1;
      m_grant[u]    = 0;
      m_data[u]     = 8'h00;
      m_err[u]      = 1'b0;
    end
  endtask

  initial begin
    bit   exp_idle;
    bit   abort;
    int   w;
    int   d;
    logic [31:0] exp_ready;
    logic [31:0] exp_sent;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    clear_err = 1'b0;
    tx_done[0] = 1'b0;
    tx_done[1] = 1'b0;
    rst_done  = 1'b0;
    force_delay = -2;
    model_reset(-1);

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      cyc = n;

      // Stimulus phases: single byte, all-valid rotation, random traffic, reset mid-transfer.
      if (n < 70) begin
        req_valid = (n == 3) ? 4'b0001 : 4'b0000;
        req_data  = {24'h0, 8'hA5};
        force_delay = 49;
      end else if (n < 250) begin
        req_valid = 4'b1111;
        req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
        force_delay = 19;
      end else if (n < 2800) begin
        force_delay = -2;
        for (int i = 0; i < NR; i++) begin
          if ($urandom_range(0, 5) == 0) begin
            req_valid[i] = ~req_valid[i];
            req_data[i*DW +: DW] = 8'($urandom);
          end
        end
      end else begin
        req_valid = 4'b1111;
        force_delay = 30;
      end

      rst_n = (n >= 3) &&
              !(n >= 2805 && !rst_done && in_xfer[0] && n > launch_cyc[0]);

      clear_err = ($urandom_range(0, 19) == 0) ||
                  (in_xfer[0] && done_cyc[0] < 0 && n == launch_cyc[0] + TO &&
                   $urandom_range(0, 1) == 0);

      for (int u = 0; u < 2; u++) begin
        tx_done[u] = (in_xfer[u] && n == done_cyc[u]) ||
                     (in_xfer[u] && n == launch_cyc[u] && $urandom_range(0, 2) == 0);
      end

      @(negedge clk);

      for (int u = 0; u < 2; u++) begin
        exp_idle  = !in_xfer[u] && n >= idle_from[u];
        w         = rr_pick(ptr[u], req_valid);
        exp_ready = (exp_idle && w >= 0) ? (32'd1 << w) : 32'd0;
        exp_sent  = (n == sent_cyc[u]) ? (32'd1 << sent_id[u]) : 32'd0;

        if (n >= 3) begin
          check_eq($sformatf("u%0d_req_ready", u), 32'(req_ready[u]), exp_ready);
          check_eq($sformatf("u%0d_tx_start", u), 32'(tx_start[u]),
                   32'(in_xfer[u] && n == launch_cyc[u]));
          check_eq($sformatf("u%0d_busy", u), 32'(busy[u]), 32'(!exp_idle));
          check_eq($sformatf("u%0d_tx_data", u), 32'(tx_data[u]), 32'(m_data[u]));
          check_eq($sformatf("u%0d_grant_id", u), 32'(grant_id[u]), 32'(m_grant[u]));
          check_eq($sformatf("u%0d_byte_sent", u), 32'(byte_sent[u]), exp_sent);
          check_eq($sformatf("u%0d_timeout_err", u), 32'(timeout_err[u]), 32'(m_err[u]));
        end

        if (rst_n) begin
          abort = 1'b0;
          if (exp_idle && w >= 0) begin
            m_data[u]     = req_data[w*DW +: DW];
            m_grant[u]    = w;
            ptr[u]        = w;
            in_xfer[u]    = 1'b1;
            launch_cyc[u] = n + 1;
            if (force_delay >= 0) begin
              done_cyc[u] = n + 2 + force_delay;
            end else begin
              d = $urandom_range(0, 9);
              if (d == 0)      done_cyc[u] = -1;
              else if (d == 1) done_cyc[u] = n + 2 + (TO - 1);
              else             done_cyc[u] = n + 2 + $urandom_range(0, 30);
            end
          end else if (in_xfer[u]) begin
            if (done_cyc[u] >= 0 && n == done_cyc[u]) begin
              in_xfer[u]   = 1'b0;
              sent_cyc[u]  = n + 1;
              sent_id[u]   = m_grant[u];
              idle_from[u] = n + 1 + gap_of(u);
            end else if (done_cyc[u] < 0 && n == launch_cyc[u] + TO) begin
              in_xfer[u]   = 1'b0;
              abort        = 1'b1;
              idle_from[u] = n + 1;
            end
          end
          if (abort) m_err[u] = 1'b1;
          else if (clear_err) m_err[u] = 1'b0;
        end
      end

      if (!rst_n) begin
        model_reset(n);
        if (n >= 3) rst_done = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Accepts one byte at a time over a valid/ready handshake and launches it into the UART with a one-cycle start pulse.
- Waits for the UART done pulse, then enforces an optional inter-byte gap before the next grant.
- Sits between client logic and the existing UART top; a done watchdog flags a hung transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width per requester
GAP_CYCLES, 0, idle clocks inserted after each tx_done before the next grant (0 = none)
TIMEOUT, 200000, max clocks in BUSY waiting for tx_done before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  bit i = requester i has a byte pending
req_data  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot accept; byte taken on the clock where valid&ready
tx_start  out  1  one-cycle launch pulse to UART
tx_data  out  DATA_W  byte presented to UART, held stable until next accept
tx_done  in  1  UART byte-complete pulse
busy  out  1  high in every state except IDLE
grant_id  out  clog2(NUM_REQ)  index of requester owning current/last transfer
byte_sent  out  NUM_REQ  one-cycle pulse on bit grant_id when its byte completes
timeout_err  out  1  sticky; set on watchdog abort
clear_err  in  1  clears timeout_err (ignored in the cycle the error sets)

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; tx_start=0; tx_data=0; grant_id=0; byte_sent=0; timeout_err=0; rr pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LAUNCH, BUSY, GAP.
- IDLE:
  - Winner = first i with req_valid[i], searching from ptr+1 modulo NUM_REQ.
  - req_ready[winner] is driven combinationally (same cycle as valid); all other ready bits are 0.
  - At the edge: tx_data<=req_data[winner]; grant_id<=winner; ptr<=winner; state->LAUNCH.
  - If no valid request, remain in IDLE.
- LAUNCH:
  - tx_start=1 for exactly this cycle.
  - Watchdog counter cleared; state->BUSY.
  - A tx_done arriving in LAUNCH is ignored.
- BUSY:
  - On tx_done: byte_sent[grant_id] pulses next cycle; state->GAP if GAP_CYCLES>0, else IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without tx_done: timeout_err<=1; state->IDLE; byte_sent is not pulsed.
- GAP: count GAP_CYCLES clocks, then IDLE.
- req_ready is 0 in all non-IDLE states.
- Latency:
  - Accept edge to tx_start high: 1 cycle.
  - tx_done to byte_sent pulse: 1 cycle.
  - tx_done to next possible accept: 1+GAP_CYCLES cycles.
- Fairness: a requester that is continuously valid is granted at least once every NUM_REQ transfers.
- Requester dropping valid before ready: no effect; a byte is never taken without valid&ready.
- clear_err and the error setting in the same cycle: set wins.
- Reset mid-transfer:
  - Return to IDLE immediately and drop tx_start.
  - The in-flight byte is abandoned; no byte_sent pulse.
- Widths: counters are sized clog2(TIMEOUT+1) and clog2(GAP_CYCLES+1), minimum 1 bit.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[7:0]=8'hA5:
  - req_ready=0001 in the same cycle.
  - tx_start pulses 1 cycle later with tx_data=A5, busy=1.
  - tx_done 50 cycles later -> byte_sent=0001 one cycle after; back to IDLE.
- All four requesters continuously valid with bytes 10/21/32/43, tx_done returned 20 cycles after each start -> UART bytes in order 10,21,32,43,10; grant_id 0,1,2,3,0.
- Requesters 1 and 3 valid after requester 2 was last served -> 3 is granted first, then 1.
- GAP_CYCLES=5:
  - tx_done at cycle T -> req_ready earliest at T+6.
  - A request held valid through the gap is not accepted early.
- TIMEOUT=100, tx_done never returned -> 100 cycles after entering BUSY: timeout_err=1, state IDLE, no byte_sent, next request accepted; clear_err=1 -> timeout_err=0 next cycle.
- Assert rst_n=0 while in BUSY -> next cycle busy=0, tx_data=0, timeout_err=0; first grant after reset goes to requester 0.
